// File: rtl/disp_pkg.sv
// ============================================================================
//  Module : disp_pkg
//  Brief  : Shared types and constants for the binary-to-BCD display path.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          DIGITS       = 8;
    localparam logic [31:0] BCD_MAX      = 32'd99_999_999;
    localparam logic [31:0] BCD_SAT      = 32'h9999_9999;
    localparam int          SHIFT_CYCLES = 32;
    // 32-bit input needs ten decimal digits before saturation is applied.
    localparam int          SCR_NIBBLES  = 10;

endpackage

`default_nettype wire

// File: rtl/bcd_nibble_adj.sv
// ============================================================================
//  Module : bcd_nibble_adj
//  Brief  : Double-dabble digit correction, adds 3 to a nibble >= 5.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_nibble_adj (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

`default_nettype wire

// File: rtl/disp_bin2bcd.sv
// ============================================================================
//  Module : disp_bin2bcd
//  Brief  : Sequential 32-bit binary to 8-digit BCD converter with saturation.
//           Optional DISP_HEX_BYPASS_EN adds i_hex_mode to pass i_bin through.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module disp_bin2bcd
    import disp_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       i_bin,
`ifdef DISP_HEX_BYPASS_EN
    input  logic                  i_hex_mode,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cs,
    output logic [DIGITS*4-1:0]   o_bcd,
    output logic                  o_ovf
);

    localparam int          SCR_W    = SCR_NIBBLES * 4;
    localparam logic [5:0]  LAST_CNT = 6'(SHIFT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [IN_W-1:0]       opnd_q, opnd_d;
    logic [SCR_W-1:0]      scr_q, scr_d;
    logic [SCR_W-1:0]      scr_adj;
    logic [5:0]            cnt_q, cnt_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic [DIGITS*4-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
`ifdef DISP_HEX_BYPASS_EN
    logic                  hex_q, hex_d;
    logic                  hold_q, hold_d;
`endif

    for (genvar g = 0; g < SCR_NIBBLES; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib_i (scr_q[4*g +: 4]),
            .nib_o (scr_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
`ifdef DISP_HEX_BYPASS_EN
        hex_d      = hex_q;
        hold_d     = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d     = i_bin;
                    scr_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (i_bin > BCD_MAX);
                    state_d    = SHIFT;
`ifdef DISP_HEX_BYPASS_EN
                    hex_d      = i_hex_mode;
                    hold_d     = i_hex_mode;
                    if (i_hex_mode) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                {scr_d, opnd_d} = {scr_adj, opnd_q} << 1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef DISP_HEX_BYPASS_EN
                // Hex results wait one extra DONE cycle so o_done lands on edge 2.
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    bcd_d   = hex_q ? opnd_q : (ovf_pend_q ? BCD_SAT : scr_q[DIGITS*4-1:0]);
                    ovf_d   = ~hex_q & ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`else
                bcd_d   = ovf_pend_q ? BCD_SAT : scr_q[DIGITS*4-1:0];
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            opnd_q     <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef DISP_HEX_BYPASS_EN
            hex_q      <= 1'b0;
            hold_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
`ifdef DISP_HEX_BYPASS_EN
            hex_q      <= hex_d;
            hold_q     <= hold_d;
`endif
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;
    assign o_cs   = done_q;
    assign o_bcd  = bcd_q;
    assign o_ovf  = ovf_q;

endmodule

`default_nettype wire

// File: doc/disp_bin2bcd.md
DISP_BIN2BCD -- requirements
Module: disp_bin2bcd

Interface
REQ-001 The block SHALL have parameter IN_W, default 32, giving the binary input width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all flops are rising-edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a conversion request sampled on the rising edge of clk.
REQ-005 The block SHALL have port i_bin, input, 32, the unsigned binary value, sampled with start.
REQ-006 The block SHALL have port o_busy, output, 1, high while a conversion is in progress.
REQ-007 The block SHALL have port o_done, output, 1, a one-cycle pulse when the result is valid.
REQ-008 The block SHALL have port o_cs, output, 1, identical to o_done; it is the write strobe for the 8-digit display driver.
REQ-009 The block SHALL have port o_bcd, output, 32, eight packed BCD digits with the least significant digit in [3:0].
REQ-010 The block SHALL have port o_ovf, output, 1, set when the last result was saturated.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch i_bin, clear the 40-bit scratch register and the 6-bit iteration counter, and enter SHIFT.
REQ-013 In SHIFT, each cycle SHALL add 3 to every scratch nibble that is >=5, then shift {scratch, operand} left by 1 (double-dabble).
REQ-014 SHIFT SHALL last exactly 32 cycles; after counter value 31 the FSM SHALL enter DONE.
REQ-015 In DONE, the block SHALL load o_bcd and o_ovf, assert o_done and o_cs for one cycle, and return to IDLE.
REQ-016 o_done SHALL rise on the 33rd rising edge after the edge that accepted start.
REQ-017 o_busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-018 If the latched value exceeds 99_999_999, o_bcd SHALL be 32'h9999_9999 and o_ovf SHALL be 1; otherwise o_ovf SHALL be 0.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queueing, and the latched operand SHALL be unaffected.
REQ-020 o_bcd and o_ovf SHALL hold their last values until the next DONE cycle.
REQ-021 Back-to-back conversions SHALL be possible with start accepted in the cycle immediately after DONE, giving a minimum spacing of 34 cycles.

Reset
REQ-022 While reset=0, the block SHALL be in IDLE with o_bcd=0, o_ovf=0, o_busy=0, o_done=0, o_cs=0, and the scratch register and counter cleared.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion with no o_done pulse; o_bcd SHALL be 0 afterwards.

Configuration
REQ-024 When macro DISP_HEX_BYPASS_EN is defined, the block SHALL add input port i_hex_mode (1 bit), sampled with start.
REQ-025 With DISP_HEX_BYPASS_EN defined and i_hex_mode=1, the FSM SHALL go IDLE->DONE directly and o_bcd SHALL equal i_bin unchanged.
REQ-026 In hex-bypass mode, o_ovf SHALL be 0 and o_done SHALL rise on the 2nd edge after start.
REQ-027 Without DISP_HEX_BYPASS_EN, the i_hex_mode port SHALL not exist and every conversion SHALL be BCD.

Structure
REQ-028 Shared package disp_pkg SHALL hold: the state enum (IDLE/SHIFT/DONE), DIGITS=8, BCD_MAX=32'd99_999_999, BCD_SAT=32'h9999_9999 and SHIFT_CYCLES=32.
REQ-029 Sub-module bcd_nibble_adj SHALL implement the combinational per-digit correction (4-bit in, 4-bit out, +3 if >=5); it SHALL be instantiated 10 times over the scratch register.

Verification
REQ-030 Test: start with i_bin=0 -> o_done at edge 33, o_bcd=32'h0000_0000, o_ovf=0.
REQ-031 Test: i_bin=12_345_678 -> o_bcd=32'h1234_5678, o_cs=1 for exactly one cycle, o_ovf=0.
REQ-032 Test: i_bin=99_999_999 -> o_bcd=32'h9999_9999 with o_ovf=0; then i_bin=100_000_000 -> o_bcd=32'h9999_9999 with o_ovf=1.
REQ-033 Test: start with 42, then start with 7 pulsed at cycle 5 -> a single o_done with o_bcd=32'h0000_0042; the second start is ignored.
REQ-034 Test: start with 555, reset=0 at cycle 10 -> no o_done, o_bcd=0; a start with 555 after release -> o_bcd=32'h0000_0555.
REQ-035 Test: with DISP_HEX_BYPASS_EN defined, i_hex_mode=1 and i_bin=32'hDEAD_BEEF -> o_done at edge 2, o_bcd=32'hDEAD_BEEF.
